// File: rtl/secded_stream_corrector_pkg.sv
// rtl/secded_stream_corrector_pkg.sv - SEC-DED helpers: check-bit count, data bit placement, decode class
package secded_pkg;

  typedef enum logic [1:0] {CLEAN, SEC_DATA, SEC_CHK, DED} secded_class_e;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_r(input int data_w);
    int r;
    r = 1;
    for (int k = 1; k < 16; k++) begin
      if ((1 << r) < data_w + r + 1) r = r + 1;
    end
    return r;
  endfunction

  // Codeword position of data bit idx: the idx-th non-power-of-two position from 3 upward.
  function automatic int pos_of_data(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    for (int p = 3; p < 512; p++) begin
      if (cnt < idx && (p & (p - 1)) != 0) begin
        cnt = cnt + 1;
        pos = p;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_stream_corrector_if.sv
// rtl/secded_stream_corrector_if.sv - beat handshake bundle for the SEC-DED stream corrector
interface secded_stream_corrector_if #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              corr_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sec;
  logic              out_ded;

  modport master (
    output in_valid, in_data, in_chk, corr_en, out_ready,
    input  in_ready, out_valid, out_data, out_sec, out_ded
  );

  modport slave (
    input  in_valid, in_data, in_chk, corr_en, out_ready,
    output in_ready, out_valid, out_data, out_sec, out_ded
  );
endinterface

// File: rtl/secded_stream_corrector_syndrome.sv
// rtl/secded_stream_corrector_syndrome.sv - combinational Hamming syndrome and overall parity
// With chk tied to zero the syndrome output is the encoder's check-bit vector.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int R      = 6
) (
  input  logic [DATA_W-1:0] data,
  input  logic [R:0]        chk,
  output logic [R-1:0]      syn,
  output logic              par
);

  logic [R-1:0] contrib [DATA_W];

  for (genvar d = 0; d < DATA_W; d++) begin : g_pos
    localparam int P = pos_of_data(d);
    assign contrib[d] = data[d] ? P[R-1:0] : '0;
  end

  always_comb begin
    syn = chk[R-1:0];
    for (int d = 0; d < DATA_W; d++) begin
      syn = syn ^ contrib[d];
    end
  end

  assign par = ^{data, chk};

endmodule

// File: rtl/secded_stream_corrector.sv
// rtl/secded_stream_corrector.sv - two-stage pipelined SEC-DED decoder with valid/ready back-pressure
// Error counters are built only when SECDED_ERR_CNT_EN is defined.
module secded_stream_corrector
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  secded_stream_corrector_if.slave bus,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         sec_cnt,
  output logic [CNT_W-1:0]         ded_cnt
);

  localparam int R = calc_r(DATA_W);
  localparam int N = DATA_W + R;
  localparam logic [R-1:0] N_R   = N[R-1:0];
  localparam logic [R-1:0] ONE_R = R'(1);

  logic [R-1:0]      in_syn;
  logic              in_par;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [R-1:0]      s1_syn;
  logic              s1_par;
  logic              s1_corr;
  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic              s2_sec;
  logic              s2_ded;
  logic              s2_ready;
  logic [DATA_W-1:0] hit;
  logic              syn_pow2;
  logic [DATA_W-1:0] corr_data;
  secded_class_e     cls;

  secded_syndrome #(.DATA_W(DATA_W), .R(R)) u_syn (
    .data (bus.in_data),
    .chk  (bus.in_chk),
    .syn  (in_syn),
    .par  (in_par)
  );

  assign s2_ready     = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s1_corr  <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= bus.in_data;
        s1_syn  <= in_syn;
        s1_par  <= in_par;
        s1_corr <= bus.corr_en;
      end
    end
  end

  // One-hot of the data bit addressed by the syndrome, if any.
  for (genvar d = 0; d < DATA_W; d++) begin : g_hit
    localparam int P = pos_of_data(d);
    assign hit[d] = (s1_syn == P[R-1:0]);
  end

  assign syn_pow2 = (s1_syn & (s1_syn - ONE_R)) == '0;

  always_comb begin
    cls = CLEAN;
    if (!s1_par) begin
      cls = (s1_syn == '0) ? CLEAN : DED;
    end else if (syn_pow2) begin
      cls = SEC_CHK;
    end else if (s1_syn > N_R) begin
      cls = DED;
    end else begin
      cls = SEC_DATA;
    end
  end

  assign corr_data = (cls == SEC_DATA && s1_corr) ? (s1_data ^ hit) : s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sec   <= 1'b0;
      s2_ded   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= corr_data;
        s2_sec  <= (cls == SEC_DATA) || (cls == SEC_CHK);
        s2_ded  <= (cls == DED);
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_sec   = s2_sec;
  assign bus.out_ded   = s2_ded;

`ifdef SECDED_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] sec_cnt_q;
  logic [CNT_W-1:0] ded_cnt_q;
  logic             out_fire;

  assign out_fire = s2_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else if (clr_cnt) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else if (out_fire) begin
      if (s2_sec && !(&sec_cnt_q)) sec_cnt_q <= sec_cnt_q + CNT_ONE;
      if (s2_ded && !(&ded_cnt_q)) ded_cnt_q <= ded_cnt_q + CNT_ONE;
    end
  end

  assign sec_cnt = sec_cnt_q;
  assign ded_cnt = ded_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign sec_cnt    = '0;
  assign ded_cnt    = '0;
`endif

endmodule

// File: tb/tb_secded_stream_corrector.sv
// tb/tb_secded_stream_corrector.sv - directed and randomized bench against a Hamming reference model
module tb_secded_stream_corrector;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int R      = 6;
  localparam int CHK_W  = 7;
  localparam int N      = DATA_W + R;
  localparam int CMAX   = 65535;
`ifdef SECDED_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              sec;
    logic              ded;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] ded_cnt;

  secded_stream_corrector_if #(.DATA_W(DATA_W), .CHK_W(CHK_W)) bus ();

  secded_stream_corrector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .sec_cnt (sec_cnt),
    .ded_cnt (ded_cnt)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    dpos [DATA_W];
  int    exp_sec = 0;
  int    exp_ded = 0;
  beat_t q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CHK_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < DATA_W; j++)
        if (((dpos[j] >> i) & 1) != 0) c[i] = c[i] ^ d[j];
    c[R] = (^d) ^ (^c[R-1:0]);
    return c;
  endfunction

  // Syndrome as XOR of positions of all set codeword bits; parity over every bit.
  function automatic beat_t ref_decode(input logic [DATA_W-1:0] d, input logic [CHK_W-1:0] c,
                                       input bit corr);
    beat_t b;
    int    s;
    bit    p;
    s = 0;
    p = c[R];
    for (int i = 0; i < R; i++) if (c[i]) begin s = s ^ (1 << i); p = !p; end
    for (int j = 0; j < DATA_W; j++) if (d[j]) begin s = s ^ dpos[j]; p = !p; end
    b.d = d; b.sec = 1'b0; b.ded = 1'b0;
    if (s == 0 && !p) begin
    end else if (!p || s > N) begin
      b.ded = 1'b1;
    end else begin
      b.sec = 1'b1;
      if (corr) for (int j = 0; j < DATA_W; j++) if (dpos[j] == s) b.d[j] = !b.d[j];
    end
    return b;
  endfunction

  task automatic count_beat(input bit s, input bit e);
    if (s && exp_sec < CMAX) exp_sec++;
    if (e && exp_ded < CMAX) exp_ded++;
  endtask

  task automatic check_cnt(input string tag);
    check_eq({tag, "_sec_cnt"}, sec_cnt, CNT_EN ? exp_sec : 0);
    check_eq({tag, "_ded_cnt"}, ded_cnt, CNT_EN ? exp_ded : 0);
  endtask

  // Called just after a rising edge with the pipeline empty.
  task automatic send_one(input string tag, input logic [31:0] d, input logic [6:0] c, input bit corr,
                          input bit clr, input logic [31:0] ed, input bit es, input bit edd);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_chk = c; bus.corr_en = corr; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.corr_en  = !corr;
    check_eq({tag, "_lat1"}, bus.out_valid, 0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, bus.out_valid, 1);
    check_eq({tag, "_data"}, bus.out_data, ed);
    check_eq({tag, "_sec"}, bus.out_sec, es);
    check_eq({tag, "_ded"}, bus.out_ded, edd);
    clr_cnt = clr;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    if (clr) begin exp_sec = 0; exp_ded = 0; end
    else count_beat(es, edd);
    check_eq({tag, "_drain"}, bus.out_valid, 0);
    check_cnt(tag);
  endtask

  initial begin
    int          p;
    int          sent;
    int          cyc;
    int          nflip;
    bit          did_rst;
    bit          last_fire;
    bit          hold_v;
    logic [31:0] hold_d;
    logic [38:0] cw;
    beat_t       pend;
    beat_t       e;

    p = 2;
    for (int j = 0; j < DATA_W; j++) begin
      p++;
      while ((p & (p - 1)) == 0) p++;
      dpos[j] = p;
    end

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_chk = '0; bus.corr_en = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_out_sec", bus.out_sec, 0);
    check_eq("rst_out_ded", bus.out_ded, 0);
    check_cnt("rst");

    send_one("clean",  32'h1, 7'h43, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
    send_one("sec",    32'h0, 7'h43, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
    send_one("ded",    32'h2, 7'h43, 1'b1, 1'b0, 32'h2, 1'b0, 1'b1);
    send_one("nocorr", 32'h0, 7'h43, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    send_one("parity", 32'h1, 7'h03, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
    send_one("clr",    32'h0, 7'h43, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0);
`ifdef SECDED_ERR_CNT_EN
    force dut.sec_cnt_q = 16'hFFFF;
    #1;
    release dut.sec_cnt_q;
    exp_sec = CMAX;
    send_one("sat", 32'h0, 7'h43, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
`endif

    sent = 0; cyc = 0; did_rst = 1'b0; last_fire = 1'b0; hold_v = 1'b0; hold_d = '0;
    pend = '0;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (sent == 500 && !did_rst) begin
        rst_n = 1'b0; bus.in_valid = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", bus.out_valid, 0);
        check_eq("mid_rst_in_ready", bus.in_ready, 1);
        check_eq("mid_rst_sec_cnt", sec_cnt, 0);
        check_eq("mid_rst_ded_cnt", ded_cnt, 0);
        q.delete();
        exp_sec = 0; exp_ded = 0;
        did_rst = 1'b1; last_fire = 1'b0; hold_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end
      if ((!bus.in_valid || last_fire)) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          cw[31:0]  = $urandom;
          cw[38:32] = encode(cw[31:0]);
          p = $urandom_range(0, 9);
          nflip = (p < 4) ? 0 : (p < 7) ? 1 : (p < 9) ? 2 : 3;
          for (int k = 0; k < nflip; k++) begin
            int idx;
            idx = $urandom_range(0, 38);
            cw[idx] = !cw[idx];
          end
          bus.in_valid = 1'b1;
          bus.in_data  = cw[31:0];
          bus.in_chk   = cw[38:32];
          bus.corr_en  = $urandom_range(0, 1);
          pend = ref_decode(cw[31:0], cw[38:32], bus.corr_en);
        end else begin
          bus.in_valid = 1'b0;
          bus.corr_en  = $urandom_range(0, 1);
        end
      end
      bus.out_ready = $urandom_range(0, 1);
      #1;
      check_cnt("rnd");
      if (hold_v) begin
        check_eq("stall_valid", bus.out_valid, 1);
        check_eq("stall_data", bus.out_data, hold_d);
      end
      if (bus.out_valid && bus.out_ready) begin
        check_eq("rnd_queue_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check_eq("rnd_data", bus.out_data, e.d);
          check_eq("rnd_sec", bus.out_sec, e.sec);
          check_eq("rnd_ded", bus.out_ded, e.ded);
          count_beat(bus.out_sec, bus.out_ded);
        end
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      last_fire = bus.in_valid && bus.in_ready;
      if (last_fire) begin
        q.push_back(pend);
        sent++;
      end
    end
    check_eq("rnd_no_timeout", cyc < 20000, 1);
    check_eq("rnd_queue_drained", q.size(), 0);
    @(negedge clk);
    check_cnt("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
